// File: rtl/core_run_ctl.sv
// Core run-state controller: qualifies PLL lock, sequences core reset,
// and supervises the running core (soft reset, watchdog, lock loss).
module core_run_ctl #(
  parameter int LOCK_WINDOW = 4,
  parameter int RESET_HOLD  = 128,
  parameter int WDT_LIMIT   = 65535
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  input  logic       wdt_enable,
  input  logic       wdt_kick,
  output logic       core_reset,
  output logic       running,
  output logic       wdt_fired,
  output logic [3:0] reset_count
);

  localparam int HW = $clog2(RESET_HOLD);
  localparam int LW = LOCK_WINDOW;

  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [15:0]   WDT_MAX   = 16'(WDT_LIMIT);

  typedef enum logic [1:0] {
    ST_QUALIFY = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [LW-1:0]   win_q, win_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [15:0]     wdt_q, wdt_d;
  logic            fired_q, fired_d;
  logic [3:0]      rcnt_q, rcnt_d;

  logic            lk_s;
  logic            lock_ok;
  logic            expire;
  logic            leave_run;

  assign lk_s    = sync_q[1];
  assign lock_ok = &win_q;
  assign expire  = wdt_enable
                 && (wdt_q == WDT_MAX)
                 && !wdt_kick;

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      state_q <= ST_QUALIFY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    fired_d   = fired_q;
    leave_run = 1'b0;
    sync_d    = {sync_q[0], pll_locked};
    win_d     = (win_q << 1) | LW'(lk_s);
    unique case (state_q)
      ST_QUALIFY: begin
        if (lock_ok) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (!lk_s) begin
          state_d = ST_QUALIFY;
          win_d   = '0;
        end else if (soft_reset_req) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RUN: begin
        // lock loss outranks soft reset, which outranks the watchdog
        if (!lk_s) begin
          state_d   = ST_QUALIFY;
          win_d     = '0;
          leave_run = 1'b1;
        end else if (soft_reset_req) begin
          state_d   = ST_HOLD;
          hold_d    = '0;
          leave_run = 1'b1;
        end else if (expire) begin
          state_d   = ST_HOLD;
          hold_d    = '0;
          fired_d   = 1'b1;
          leave_run = 1'b1;
        end
      end
      default: begin
        state_d = ST_QUALIFY;
        win_d   = '0;
      end
    endcase
  end

  // watchdog only counts while staying in RUN; any entry starts from zero
  always_comb begin
    wdt_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN
        && wdt_enable) begin
      wdt_d = wdt_kick ? 16'd0 : wdt_q + 16'd1;
    end
  end

  always_comb begin
    rcnt_d = rcnt_q;
    if (leave_run && rcnt_q != 4'hF) begin
      rcnt_d = rcnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      win_q   <= '0;
      hold_q  <= '0;
      wdt_q   <= '0;
      fired_q <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      wdt_q   <= wdt_d;
      fired_q <= fired_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    core_reset = (state_q != ST_RUN);
    running    = (state_q == ST_RUN);
  end

  assign wdt_fired   = fired_q;
  assign reset_count = rcnt_q;

endmodule

// File: doc/core_run_ctl.md
Name: core_run_ctl

Overview:
- Core run-state controller between the PLL and the CFM core.
- Qualifies PLL lock and holds the core in reset for a fixed delay before releasing it.
- While the core runs, it handles core-initiated soft resets, an optional watchdog, and lock loss.
- Sits in the board top, clocked by the PLL output. Its core_reset output drives the core's reset input.

Parameters:
LOCK_WINDOW, 4, consecutive synchronized lock samples required before leaving QUALIFY (1..16)
RESET_HOLD, 128, cycles core_reset stays asserted in HOLD (2..65536)
WDT_LIMIT, 65535, watchdog timeout in cycles since last kick (1..65535, 16-bit counter)

Ports:
clk_core  input  1  core clock (PLL output)
reset  input  1  asynchronous, active-high reset of this block (board drives it from ~dtr)
pll_locked  input  1  raw PLL lock; asynchronous, synchronized internally
soft_reset_req  input  1  single-cycle pulse from the core I/O: request a core reset
wdt_enable  input  1  level; watchdog counts only while high and state==RUN
wdt_kick  input  1  single-cycle pulse: clear the watchdog counter
core_reset  output  1  active-high reset to the core
running  output  1  high exactly when state==RUN
wdt_fired  output  1  sticky flag: a watchdog expiry has occurred since block reset
reset_count  output  4  saturating count of HOLD re-entries from RUN

Behaviour:
- Async reset, effective immediately:
  - state=QUALIFY; sync flops, window, hold counter, watchdog counter all 0.
  - core_reset=1, running=0, wdt_fired=0, reset_count=0.
- Lock path: pll_locked passes through a 2-flop synchronizer (lk_s). lk_s shifts into a LOCK_WINDOW-bit register every cycle. lock_ok = AND of all window bits.
- QUALIFY:
  - core_reset=1.
  - The cycle lock_ok=1, go to HOLD with hold_cnt=0.
- HOLD:
  - core_reset=1; hold_cnt increments each cycle.
  - At hold_cnt==RESET_HOLD-1, go to RUN.
- RUN:
  - core_reset=0, running=1 (both registered from state).
  - If wdt_enable=1: wdt_cnt increments each cycle; wdt_kick clears it to 0.
  - If wdt_enable=0: wdt_cnt holds at 0.
- RUN exits, priority highest first:
  - lk_s==0 -> QUALIFY; window cleared.
  - soft_reset_req -> HOLD, hold_cnt=0.
  - wdt_cnt==WDT_LIMIT and no kick this cycle -> HOLD, hold_cnt=0, wdt_fired<=1.
  - Every RUN->HOLD or RUN->QUALIFY transition increments reset_count, saturating at 15.
- Lock loss in HOLD (lk_s==0): go to QUALIFY and clear the window. reset_count is not incremented.
- soft_reset_req in HOLD restarts hold_cnt at 0. Ignored in QUALIFY.
- Kick in the same cycle as expiry: the kick wins; no HOLD entry.
- wdt_cnt is cleared on every entry to RUN.
- Release latency: with pll_locked=1 from reset deassert, LOCK_WINDOW=4, RESET_HOLD=128, core_reset falls after the 135th rising clk_core edge. General form: 2+LOCK_WINDOW+1+RESET_HOLD.
- Mid-operation reset: async assertion in any state returns all outputs to their reset values in the same cycle.
- No combinational path from any input to any output.

Test Plan:
- Power-up: hold pll_locked=1 and deassert reset -> core_reset high through edge 134, low at edge 135, running=1, reset_count=0.
- Lock glitch: drop pll_locked for 2 cycles during QUALIFY after 3 good samples -> the window restarts; release comes 2+4+1+128 cycles after the last low sample clears the synchronizer.
- Soft reset: pulse soft_reset_req in RUN -> core_reset=1 next cycle for exactly 128 cycles, then RUN; reset_count=1.
- Watchdog: set WDT_LIMIT=100 and wdt_enable=1 with no kicks:
  - core_reset rises 101 cycles after RUN entry; wdt_fired=1 and stays 1.
  - Kicks every 50 cycles -> no reset.
  - Kick on the expiry cycle -> no reset.
- Priority and saturation:
  - Lock loss and soft_reset_req in the same RUN cycle -> QUALIFY, not HOLD.
  - Force 17 soft resets -> reset_count stops at 15.
- Async reset mid-HOLD (hold_cnt=60) -> core_reset=1, running=0, wdt_fired=0, reset_count=0 immediately; the full 135-cycle sequence repeats.
